// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer.
// MAIN drives out_*; SKID absorbs the one extra entry that can arrive in the
// cycle downstream stalls, so in_ready is a flop and never depends on out_ready.
// Also provides synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int LANES          = 2,
    parameter int LANE_W         = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*LANE_W-1:0] out_data,
    input  logic                    flush,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        bp_cnt,
    input  logic                    bp_clr
);

    localparam int DW = LANES * LANE_W;

    // Encoding doubles as the entry count driven on occupancy.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    main_data, main_data_nxt;
    logic [LANES-1:0] main_lane, main_lane_nxt;
    logic [DW-1:0]    skid_data, skid_data_nxt;
    logic [LANES-1:0] skid_lane, skid_lane_nxt;

    logic in_fire;
    logic out_fire;

    assign in_fire        = in_valid & in_ready;
    assign out_fire       = out_valid & out_ready;
    assign out_data       = main_data;
    assign out_lane_valid = main_lane;
    assign occupancy      = state;

    // Next-state and slot-update logic; flush overrides every handshake.
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_lane_nxt = main_lane;
        skid_data_nxt = skid_data;
        skid_lane_nxt = skid_lane;

        if (flush) begin
            state_nxt     = S_EMPTY;
            main_lane_nxt = '0;
            skid_lane_nxt = '0;
            if (CLEAR_ON_FLUSH) begin
                main_data_nxt = '0;
                skid_data_nxt = '0;
            end
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt     = S_ONE;
                        main_data_nxt = in_data;
                        main_lane_nxt = in_lane_valid;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_nxt = in_data;
                        main_lane_nxt = in_lane_valid;
                    end else if (in_fire) begin
                        state_nxt     = S_TWO;
                        skid_data_nxt = in_data;
                        skid_lane_nxt = in_lane_valid;
                    end else if (out_fire) begin
                        state_nxt     = S_EMPTY;
                        main_lane_nxt = '0;
                        if (CLEAR_ON_FLUSH) main_data_nxt = '0;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        state_nxt     = S_ONE;
                        main_data_nxt = skid_data;
                        main_lane_nxt = skid_lane;
                        skid_lane_nxt = '0;
                        if (CLEAR_ON_FLUSH) skid_data_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = S_EMPTY;
                    main_lane_nxt = '0;
                    skid_lane_nxt = '0;
                end
            endcase
        end
    end

    // State and slot registers; handshake flags are decoded from the next state.
    // NOTE: payload slots are reset too, so out_data reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_lane <= '0;
            skid_data <= '0;
            skid_lane <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state     <= state_nxt;
            out_valid <= (state_nxt != S_EMPTY);
            in_ready  <= (state_nxt != S_TWO);
            main_data <= main_data_nxt;
            main_lane <= main_lane_nxt;
            skid_data <= skid_data_nxt;
            skid_lane <= skid_lane_nxt;
        end
    end

    // Saturating stall counter; clear beats increment, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_cnt <= '0;
        end else if (bp_clr) begin
            bp_cnt <= '0;
        end else if (out_valid && !out_ready && !(&bp_cnt)) begin
            bp_cnt <= bp_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for streaming, skid fill,
// flush and lane bits, plus hand sequences for async reset and counter saturation.
module tb_pipe_stage_skid;

    localparam int LANES  = 2;
    localparam int LANE_W = 32;
    localparam int DW     = LANES * LANE_W;
    localparam int CNT_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_lane_valid;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_lane_valid;
    logic [DW-1:0]    out_data;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bp_cnt;
    logic             bp_clr;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .LANES(LANES), .LANE_W(LANE_W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_data(out_data),
        .flush(flush), .occupancy(occupancy),
        .bp_cnt(bp_cnt), .bp_clr(bp_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [LANES-1:0] ilv;
        logic [DW-1:0]    id;
        logic             ordy;
        logic             fl;
        logic             clr;
        logic             eov;
        logic [LANES-1:0] elv;
        logic [DW-1:0]    ed;
        logic [1:0]       eocc;
        logic             eir;
        logic [CNT_W-1:0] ebp;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic iv, logic [1:0] ilv, logic [63:0] id, logic ordy,
                                logic fl, logic clr, logic eov, logic [1:0] elv,
                                logic [63:0] ed, logic [1:0] eocc, logic eir, logic [2:0] ebp);
        vec_t v;
        v.iv = iv; v.ilv = ilv; v.id = id; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.eov = eov; v.elv = elv; v.ed = ed; v.eocc = eocc; v.eir = eir; v.ebp = ebp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic eov, input logic [1:0] elv,
                             input logic [63:0] ed, input logic [1:0] eocc,
                             input logic eir, input logic [2:0] ebp);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
        check({tag, ".lane"},      64'(out_lane_valid), 64'(elv));
        check({tag, ".data"},      out_data, ed);
        check({tag, ".occ"},       64'(occupancy), 64'(eocc));
        check({tag, ".in_ready"},  64'(in_ready), 64'(eir));
        check({tag, ".bp_cnt"},    64'(bp_cnt), 64'(ebp));
    endtask

    task automatic drive(input logic iv, input logic [1:0] ilv, input logic [63:0] id,
                         input logic ordy, input logic fl, input logic clr);
        in_valid = iv; in_lane_valid = ilv; in_data = id;
        out_ready = ordy; flush = fl; bp_clr = clr;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming with out_ready high.
        vecs[0]  = mk(1, 2'b11, 64'h1,    1, 0, 0,  1, 2'b11, 64'h1,    1, 1, 0);
        vecs[1]  = mk(1, 2'b11, 64'h2,    1, 0, 0,  1, 2'b11, 64'h2,    1, 1, 0);
        vecs[2]  = mk(1, 2'b11, 64'h3,    1, 0, 0,  1, 2'b11, 64'h3,    1, 1, 0);
        vecs[3]  = mk(0, 2'b00, 64'h0,    1, 0, 0,  0, 2'b00, 64'h0,    0, 1, 0);
        // Skid fill, refused push while full, then drain in order.
        vecs[4]  = mk(1, 2'b11, 64'hAAAA, 0, 0, 0,  1, 2'b11, 64'hAAAA, 1, 1, 0);
        vecs[5]  = mk(1, 2'b11, 64'hBBBB, 0, 0, 0,  1, 2'b11, 64'hAAAA, 2, 0, 1);
        vecs[6]  = mk(1, 2'b11, 64'hCCCC, 0, 0, 0,  1, 2'b11, 64'hAAAA, 2, 0, 2);
        vecs[7]  = mk(0, 2'b00, 64'h0,    1, 0, 0,  1, 2'b11, 64'hBBBB, 1, 1, 2);
        vecs[8]  = mk(0, 2'b00, 64'h0,    1, 0, 0,  0, 2'b00, 64'h0,    0, 1, 2);
        // Flush from TWO with out_ready high, then flush from ONE with a live push.
        vecs[9]  = mk(1, 2'b11, 64'h11,   0, 0, 0,  1, 2'b11, 64'h11,   1, 1, 2);
        vecs[10] = mk(1, 2'b11, 64'h22,   0, 0, 0,  1, 2'b11, 64'h11,   2, 0, 3);
        vecs[11] = mk(1, 2'b11, 64'h33,   1, 1, 0,  0, 2'b00, 64'h0,    0, 1, 3);
        vecs[12] = mk(1, 2'b11, 64'h44,   0, 0, 0,  1, 2'b11, 64'h44,   1, 1, 3);
        vecs[13] = mk(1, 2'b01, 64'h55,   0, 1, 0,  0, 2'b00, 64'h0,    0, 1, 4);
        vecs[14] = mk(0, 2'b00, 64'h0,    1, 0, 0,  0, 2'b00, 64'h0,    0, 1, 4);
        // Partial lane valid, stall, clear during a stall, pop.
        vecs[15] = mk(1, 2'b10, 64'h0000_0005_0000_0000, 0, 0, 0,
                      1, 2'b10, 64'h0000_0005_0000_0000, 1, 1, 4);
        vecs[16] = mk(0, 2'b00, 64'h0,    0, 0, 0,  1, 2'b10, 64'h0000_0005_0000_0000, 1, 1, 5);
        vecs[17] = mk(0, 2'b00, 64'h0,    0, 0, 1,  1, 2'b10, 64'h0000_0005_0000_0000, 1, 1, 0);
        vecs[18] = mk(0, 2'b00, 64'h0,    1, 0, 0,  0, 2'b00, 64'h0,    0, 1, 0);
        // All-lanes-invalid bubble is still a real entry.
        vecs[19] = mk(1, 2'b00, 64'h77,   1, 0, 0,  1, 2'b00, 64'h77,   1, 1, 0);
        vecs[20] = mk(0, 2'b00, 64'h0,    1, 0, 0,  0, 2'b00, 64'h0,    0, 1, 0);

        // Reset state, observed asynchronously before any clock edge.
        rst = 1'b1;
        drive(0, 2'b00, 64'h0, 0, 0, 0);
        #3;
        check_all("reset", 0, 2'b00, 64'h0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ilv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].eov, vecs[i].elv, vecs[i].ed,
                      vecs[i].eocc, vecs[i].eir, vecs[i].ebp);
        end

        // Async reset between edges while one entry is held and stalling.
        @(negedge clk);
        drive(1, 2'b11, 64'h99, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("ar_load", 1, 2'b11, 64'h99, 1, 1, 0);
        drive(0, 2'b00, 64'h0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("ar_pre_bp", 64'(bp_cnt), 64'd1);
        rst = 1'b1;
        #1;
        check_all("ar_async", 0, 2'b00, 64'h0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2'b11, 64'hAB, 0, 0, 0);
        #1;
        check("ar_ready_first_edge", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_all("ar_first_push", 1, 2'b11, 64'hAB, 1, 1, 0);

        // Counter saturation under a long stall, then clear during a stall.
        @(negedge clk);
        drive(0, 2'b00, 64'h0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d", k), 64'(bp_cnt), (k > 7) ? 64'd7 : 64'(k));
        end
        check("sat_hold_data", out_data, 64'hAB);
        @(negedge clk);
        drive(0, 2'b00, 64'h0, 0, 0, 1);
        @(posedge clk);
        #1;
        check("clr_wins", 64'(bp_cnt), 64'd0);
        @(negedge clk);
        drive(0, 2'b00, 64'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("after_clr", 64'(bp_cnt), 64'd1);
        @(negedge clk);
        drive(0, 2'b00, 64'h0, 1, 0, 0);
        @(posedge clk);
        #1;
        check_all("final_drain", 0, 2'b00, 64'h0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generalised pipeline-stage register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).
- Carries a packed multi-lane payload across a valid/ready handshake, with a two-entry skid buffer so that `in_ready` is registered and never combinationally dependent on `out_ready`.
- Adds synchronous flush with optional payload clearing and a saturating back-pressure cycle counter for performance monitoring.
- Replaces per-stage hand-written stall/flush registers.

Parameters:
- LANES, 2, number of issue lanes carried per entry (≥1)
- LANE_W, 32, payload bits per lane (≥1)
- CLEAR_ON_FLUSH, 1, 1 = zero stored payloads on flush/pop; 0 = payload retained, only valids cleared
- CNT_W, 16, width of back-pressure counter (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle (registered)
- in_lane_valid  in  LANES  per-lane valid bits of incoming entry
- in_data  in  LANES*LANE_W  packed payload, lane 0 in LSBs
- out_valid  out  1  head entry valid (registered)
- out_ready  in  1  downstream accepts head entry
- out_lane_valid  out  LANES  per-lane valid of head entry (registered)
- out_data  out  LANES*LANE_W  head payload (registered)
- flush  in  1  synchronous discard of all held and incoming entries
- occupancy  out  2  entries held: 0, 1 or 2
- bp_cnt  out  CNT_W  saturating count of cycles with out_valid & ~out_ready
- bp_clr  in  1  synchronous clear of bp_cnt

Behaviour:
- Storage and handshake:
  - Two slots: MAIN (drives out_*) and SKID.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = ~skid_valid, registered.
- State machine on occupancy, when neither rst nor flush is active:
  - EMPTY, in_fire → ONE; MAIN ← in.
  - ONE, in_fire & out_fire → ONE; MAIN ← in.
  - ONE, in_fire & ~out_fire → TWO; SKID ← in.
  - ONE, ~in_fire & out_fire → EMPTY.
  - ONE, neither → ONE; hold.
  - TWO, out_fire → ONE; MAIN ← SKID; SKID cleared. in_fire is impossible in TWO.
  - TWO, ~out_fire → TWO; hold.
- Ordering: strict FIFO. Entries leave in arrival order; none are duplicated or dropped except by flush or reset.
- Latency: an entry accepted into an empty stage appears on out_* the next cycle. Throughput is one entry per cycle while out_ready is held high.
- Held payload stability: while out_valid & ~out_ready, out_data and out_lane_valid are stable.
- Lane bits: in_lane_valid is stored verbatim. An entry with in_lane_valid == 0 is still a legal entry (bubble that carries status).
- Flush:
  - Priority is below rst and above all other activity.
  - The next state is EMPTY, out_valid = 0, in_ready = 1, lane valids = 0.
  - Any in_fire or out_fire in the flush cycle is ignored: nothing is captured. Downstream must not rely on a transfer in a flush cycle.
  - If CLEAR_ON_FLUSH = 1, both payloads are zeroed.
- Pop clearing: when CLEAR_ON_FLUSH = 1, a slot that becomes empty after a pop has its payload zeroed. out_data = 0 whenever out_valid = 0.
- Reset (asynchronous, any cycle including mid-transfer):
  - out_valid = 0, in_ready = 1, occupancy = 0, out_lane_valid = 0, out_data = 0, SKID cleared, bp_cnt = 0.
  - On the first edge after deassertion, in_ready is already 1.
- bp_cnt:
  - Increments when out_valid & ~out_ready and the counter is not all-ones.
  - Saturates at 2^CNT_W−1.
  - bp_clr forces 0 and wins over increment.
  - flush does not affect bp_cnt.
- occupancy equals the number of valid slots and is registered, consistent with out_valid and in_ready.

Test Plan:
- Streaming: LANES = 2, LANE_W = 32, out_ready = 1, push 0x1,0x2,0x3… on consecutive cycles → out_data shows the same sequence one cycle later, occupancy stays ≤ 1, in_ready never drops.
- Skid fill: push A = 0xAAAA, B = 0xBBBB with out_ready = 0 → occupancy 2, in_ready = 0, out_data = A held. Raise out_ready → A then B pop on consecutive cycles; in_ready returns to 1 one cycle after the first pop.
- Flush mid-transfer: occupancy 2, assert flush with in_valid = 1 and out_ready = 1 → next cycle occupancy 0, out_valid = 0, out_data = 0, and the flush-cycle input does not appear later.
- Async reset: assert rst between clock edges while occupancy = 1 → outputs clear immediately, without waiting for an edge; in_ready = 1 and bp_cnt = 0.
- Counter: CNT_W = 3, hold out_valid with out_ready = 0 for 10 cycles → bp_cnt saturates at 7. Assert bp_clr together with a stall cycle → bp_cnt = 0.
- Lane bits: push in_lane_valid = 2'b10 with payload {0x5, 0x0} → out_lane_valid = 2'b10, out_data = {0x5, 0x0}, entry counted in occupancy.
